// File: rtl/watch_pkg.sv
// Shared definitions for the watch time counter.
//   mode_e      : operating modes, encoding matches the external mode output
//   BLANK       : BCD code the 7-segment decoder renders as all segments off
//   *_LIMIT     : highest value each time field reaches before wrapping
package watch_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10
   } mode_e;

   localparam logic [3:0] BLANK = 4'hF;

   localparam int unsigned SEC_LIMIT  = 59;
   localparam int unsigned MIN_LIMIT  = 59;
   localparam int unsigned HR24_LIMIT = 23;
   localparam int unsigned HR12_LIMIT = 12;

   function automatic int unsigned tens_of(input int unsigned value);
      return value / 10;
   endfunction

   function automatic int unsigned ones_of(input int unsigned value);
      return value % 10;
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with separate tens/ones registers.
//   clk, rst_n   : clock, synchronous active-low reset (loads RST_TENS/RST_ONES)
//   inc          : advance by one; at MAX_TENS/MAX_ONES wraps to 0/MIN_ONES
//   clr          : load the wrap value 0/MIN_ONES
//   blank        : registered display digits show BLANK instead of the value
//   tens, ones   : registered display digits
//   carry        : combinational, high when this inc wraps the counter
module bcd_mod_counter
   import watch_pkg::*;
#(
   parameter int unsigned MAX_TENS = 5,
   parameter int unsigned MAX_ONES = 9,
   parameter int unsigned MIN_ONES = 0,
   parameter int unsigned RST_TENS = 0,
   parameter int unsigned RST_ONES = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       clr,
   input  logic       blank,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       carry
);

   logic [3:0] val_tens, val_ones;
   logic [3:0] nxt_tens, nxt_ones;
   logic       at_max;

   always_comb begin
      at_max   = (val_tens == 4'(MAX_TENS)) && (val_ones == 4'(MAX_ONES));
      carry    = inc && at_max;
      nxt_tens = val_tens;
      nxt_ones = val_ones;
      if (clr) begin
         nxt_tens = 4'd0;
         nxt_ones = 4'(MIN_ONES);
      end else if (inc) begin
         if (at_max) begin
            nxt_tens = 4'd0;
            nxt_ones = 4'(MIN_ONES);
         end else if (val_ones == 4'd9) begin
            nxt_tens = val_tens + 4'd1;
            nxt_ones = 4'd0;
         end else begin
            nxt_ones = val_ones + 4'd1;
         end
      end
   end

   // Display digits are registered from the next value so they move in
   // the same cycle as the count itself.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         val_tens <= 4'(RST_TENS);
         val_ones <= 4'(RST_ONES);
         tens     <= 4'(RST_TENS);
         ones     <= 4'(RST_ONES);
      end else begin
         val_tens <= nxt_tens;
         val_ones <= nxt_ones;
         tens     <= blank ? BLANK : nxt_tens;
         ones     <= blank ? BLANK : nxt_ones;
      end
   end

endmodule

// File: rtl/watch_time_counter.sv
// Wristwatch time-of-day counter with a RUN / SET_HR / SET_MIN setting FSM.
//   clk, rst_n          : clock, synchronous active-low reset
//   tick_1hz            : one-cycle pulse per second
//   mode_btn, inc_btn   : one-cycle debounced button pulses
//   hr_*, min_*, sec_*  : registered BCD digits (BLANK while the set field blinks)
//   mode                : current mode (00 RUN, 01 SET_HR, 10 SET_MIN)
//   day_pulse           : one-cycle pulse at the midnight rollover
module watch_time_counter
   import watch_pkg::*;
#(
   parameter bit H24 = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [3:0] hr_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [1:0] mode,
   output logic       day_pulse
);

   localparam int unsigned HR_LIMIT = H24 ? HR24_LIMIT : HR12_LIMIT;
   localparam int unsigned HR_MIN   = H24 ? 0 : 1;
   localparam int unsigned HR_RST   = H24 ? 0 : HR12_LIMIT;

   mode_e state_q, state_d;
   logic  blink_q, blink_d;
   logic  day_d;
   logic  inc_ok;
   logic  sec_inc, sec_clr, min_inc, hr_inc;
   logic  sec_carry, min_carry, hr_carry;
   logic  min_blank, hr_blank;

   always_comb begin
      state_d = state_q;
      if (mode_btn) begin
         unique case (state_q)
            RUN:     state_d = SET_HR;
            SET_HR:  state_d = SET_MIN;
            SET_MIN: state_d = RUN;
            default: state_d = RUN;
         endcase
      end

      blink_d = blink_q;
      if (state_d != state_q) begin
         blink_d = 1'b0;
      end else if ((state_q != RUN) && tick_1hz) begin
         blink_d = ~blink_q;
      end

      // mode_btn wins over a coincident inc_btn
      inc_ok  = inc_btn && !mode_btn;
      sec_inc = (state_q == RUN) && tick_1hz;
      sec_clr = (state_q == SET_MIN) && mode_btn;
      min_inc = ((state_q == RUN) && sec_carry) || ((state_q == SET_MIN) && inc_ok);
      hr_inc  = ((state_q == RUN) && min_carry) || ((state_q == SET_HR) && inc_ok);

      hr_blank  = (state_d == SET_HR) && blink_d;
      min_blank = (state_d == SET_MIN) && blink_d;

      // In RUN the hour display is never blanked, so it holds the true hour.
      // 12-hour midnight is the 11 -> 12 step, not the 12 -> 01 wrap.
      if (H24) begin
         day_d = sec_carry && min_carry && hr_carry;
      end else begin
         day_d = sec_carry && min_carry && (hr_tens == 4'd1) && (hr_ones == 4'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= RUN;
         blink_q   <= 1'b0;
         day_pulse <= 1'b0;
      end else begin
         state_q   <= state_d;
         blink_q   <= blink_d;
         day_pulse <= day_d;
      end
   end

   assign mode = state_q;

   bcd_mod_counter #(
      .MAX_TENS (tens_of(SEC_LIMIT)),
      .MAX_ONES (ones_of(SEC_LIMIT)),
      .MIN_ONES (0),
      .RST_TENS (0),
      .RST_ONES (0)
   ) u_sec (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sec_inc),
      .clr   (sec_clr),
      .blank (1'b0),
      .tens  (sec_tens),
      .ones  (sec_ones),
      .carry (sec_carry)
   );

   bcd_mod_counter #(
      .MAX_TENS (tens_of(MIN_LIMIT)),
      .MAX_ONES (ones_of(MIN_LIMIT)),
      .MIN_ONES (0),
      .RST_TENS (0),
      .RST_ONES (0)
   ) u_min (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (min_inc),
      .clr   (1'b0),
      .blank (min_blank),
      .tens  (min_tens),
      .ones  (min_ones),
      .carry (min_carry)
   );

   bcd_mod_counter #(
      .MAX_TENS (tens_of(HR_LIMIT)),
      .MAX_ONES (ones_of(HR_LIMIT)),
      .MIN_ONES (HR_MIN),
      .RST_TENS (tens_of(HR_RST)),
      .RST_ONES (ones_of(HR_RST))
   ) u_hr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hr_inc),
      .clr   (1'b0),
      .blank (hr_blank),
      .tens  (hr_tens),
      .ones  (hr_ones),
      .carry (hr_carry)
   );

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed bench: instance a runs 24-hour, instance b runs 12-hour.
module tb_watch_time_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst_n, a_tick, a_mode_btn, a_inc_btn;
   logic [3:0] a_hr_t, a_hr_o, a_min_t, a_min_o, a_sec_t, a_sec_o;
   logic [1:0] a_mode;
   logic       a_day;
   logic       b_rst_n, b_tick, b_mode_btn, b_inc_btn;
   logic [3:0] b_hr_t, b_hr_o, b_min_t, b_min_o, b_sec_t, b_sec_o;
   logic [1:0] b_mode;
   logic       b_day;

   logic [23:0] a_time, b_time;
   assign a_time = {a_hr_t, a_hr_o, a_min_t, a_min_o, a_sec_t, a_sec_o};
   assign b_time = {b_hr_t, b_hr_o, b_min_t, b_min_o, b_sec_t, b_sec_o};

   int errors = 0;
   int checks = 0;

   watch_time_counter #(.H24(1'b1)) dut_a (
      .clk       (clk),
      .rst_n     (a_rst_n),
      .tick_1hz  (a_tick),
      .mode_btn  (a_mode_btn),
      .inc_btn   (a_inc_btn),
      .hr_tens   (a_hr_t),
      .hr_ones   (a_hr_o),
      .min_tens  (a_min_t),
      .min_ones  (a_min_o),
      .sec_tens  (a_sec_t),
      .sec_ones  (a_sec_o),
      .mode      (a_mode),
      .day_pulse (a_day)
   );

   watch_time_counter #(.H24(1'b0)) dut_b (
      .clk       (clk),
      .rst_n     (b_rst_n),
      .tick_1hz  (b_tick),
      .mode_btn  (b_mode_btn),
      .inc_btn   (b_inc_btn),
      .hr_tens   (b_hr_t),
      .hr_ones   (b_hr_o),
      .min_tens  (b_min_t),
      .min_ones  (b_min_o),
      .sec_tens  (b_sec_t),
      .sec_ones  (b_sec_o),
      .mode      (b_mode),
      .day_pulse (b_day)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle on instance a with the given inputs, outputs sampled 1 after the edge.
   task automatic step_a(input int n, input logic r, input logic t, input logic m,
                         input logic i);
      for (int k = 0; k < n; k++) begin
         a_rst_n = r; a_tick = t; a_mode_btn = m; a_inc_btn = i;
         @(posedge clk);
         #1;
         a_rst_n = 1'b1; a_tick = 1'b0; a_mode_btn = 1'b0; a_inc_btn = 1'b0;
      end
   endtask

   task automatic step_b(input int n, input logic r, input logic t, input logic m,
                         input logic i);
      for (int k = 0; k < n; k++) begin
         b_rst_n = r; b_tick = t; b_mode_btn = m; b_inc_btn = i;
         @(posedge clk);
         #1;
         b_rst_n = 1'b1; b_tick = 1'b0; b_mode_btn = 1'b0; b_inc_btn = 1'b0;
      end
   endtask

   initial begin
      a_rst_n = 1'b0; a_tick = 1'b0; a_mode_btn = 1'b0; a_inc_btn = 1'b0;
      b_rst_n = 1'b0; b_tick = 1'b0; b_mode_btn = 1'b0; b_inc_btn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;

      // ---------------- 24-hour instance ----------------
      chk("a_reset_time", a_time, 24'h000000);
      chk("a_reset_mode", a_mode, 2'b00);
      chk("a_reset_day",  a_day,  1'b0);

      step_a(1, 1, 0, 1, 0);
      chk("a_enter_set_hr", a_mode, 2'b01);
      step_a(23, 1, 0, 0, 1);
      chk("a_set_hr_23", a_time, 24'h230000);
      step_a(1, 1, 0, 1, 0);
      chk("a_enter_set_min", a_mode, 2'b10);
      step_a(59, 1, 0, 0, 1);
      chk("a_set_min_59", a_time, 24'h235900);
      step_a(1, 1, 0, 1, 0);
      chk("a_back_to_run", a_mode, 2'b00);
      step_a(58, 1, 1, 0, 0);
      chk("a_run_235958", a_time, 24'h235958);
      step_a(1, 1, 1, 0, 0);
      chk("a_run_235959", a_time, 24'h235959);
      chk("a_no_day_early", a_day, 1'b0);
      step_a(1, 1, 1, 0, 0);
      chk("a_midnight_time", a_time, 24'h000000);
      chk("a_midnight_day", a_day, 1'b1);
      step_a(1, 1, 0, 0, 0);
      chk("a_day_one_cycle", a_day, 1'b0);

      step_a(15, 1, 1, 0, 0);
      chk("a_run_000015", a_time, 24'h000015);
      step_a(1, 1, 0, 0, 1);
      chk("a_inc_ignored_run", a_time, 24'h000015);

      step_a(1, 1, 0, 1, 0);
      step_a(7, 1, 0, 0, 1);
      step_a(1, 1, 0, 1, 0);
      chk("a_set_min_mode", a_mode, 2'b10);
      step_a(1, 1, 1, 0, 0);
      chk("a_min_blank_sec_frozen", a_time, 24'h07FF15);
      step_a(1, 1, 1, 0, 0);
      chk("a_min_unblank", a_time, 24'h070015);
      step_a(59, 1, 0, 0, 1);
      chk("a_min_59", a_time, 24'h075915);
      step_a(1, 1, 0, 0, 1);
      chk("a_min_wrap_no_carry", a_time, 24'h070015);
      step_a(1, 1, 0, 1, 0);
      chk("a_exit_clears_sec", a_time, 24'h070000);
      chk("a_exit_mode_run", a_mode, 2'b00);

      step_a(1, 1, 0, 1, 0);
      step_a(1, 1, 1, 0, 0);
      chk("a_hr_blink_on", a_time, 24'hFF0000);
      step_a(1, 1, 1, 0, 0);
      chk("a_hr_blink_off", a_time, 24'h070000);
      step_a(1, 1, 1, 0, 0);
      chk("a_hr_blink_on2", a_time, 24'hFF0000);
      step_a(1, 1, 0, 1, 1);
      chk("a_mode_over_inc_mode", a_mode, 2'b10);
      chk("a_mode_over_inc_time", a_time, 24'h070000);

      step_a(1, 1, 1, 0, 1);
      chk("a_tick_inc_blank", a_time, 24'h07FF00);
      step_a(1, 1, 1, 0, 0);
      chk("a_tick_inc_value", a_time, 24'h070100);

      step_a(1, 1, 0, 1, 0);
      step_a(15, 1, 1, 0, 0);
      step_a(2, 1, 0, 1, 0);
      step_a(32, 1, 0, 0, 1);
      chk("a_preset_073315", a_time, 24'h073315);
      step_a(1, 1, 1, 0, 0);
      chk("a_preset_blank", a_time, 24'h07FF15);
      step_a(1, 0, 1, 1, 1);
      chk("a_rst_in_set_time", a_time, 24'h000000);
      chk("a_rst_in_set_mode", a_mode, 2'b00);
      chk("a_rst_in_set_day", a_day, 1'b0);
      step_a(1, 1, 0, 0, 0);
      chk("a_after_rst_hold", a_time, 24'h000000);

      // ---------------- 12-hour instance ----------------
      chk("b_reset_time", b_time, 24'h120000);
      chk("b_reset_mode", b_mode, 2'b00);
      step_b(1, 1, 0, 1, 0);
      step_b(11, 1, 0, 0, 1);
      chk("b_hr_11", b_time, 24'h110000);
      step_b(1, 1, 0, 0, 1);
      chk("b_hr_12", b_time, 24'h120000);
      step_b(1, 1, 0, 0, 1);
      chk("b_hr_wrap_01", b_time, 24'h010000);

      step_b(10, 1, 0, 0, 1);
      step_b(1, 1, 0, 1, 0);
      step_b(59, 1, 0, 0, 1);
      step_b(1, 1, 0, 1, 0);
      chk("b_preset_1159", b_time, 24'h115900);
      step_b(59, 1, 1, 0, 0);
      chk("b_run_115959", b_time, 24'h115959);
      chk("b_no_day_early", b_day, 1'b0);
      step_b(1, 1, 1, 0, 0);
      chk("b_midnight_time", b_time, 24'h120000);
      chk("b_midnight_day", b_day, 1'b1);
      step_b(1, 1, 0, 0, 0);
      chk("b_day_one_cycle", b_day, 1'b0);

      step_b(2, 1, 0, 1, 0);
      step_b(59, 1, 0, 0, 1);
      step_b(1, 1, 0, 1, 0);
      step_b(59, 1, 1, 0, 0);
      chk("b_run_125959", b_time, 24'h125959);
      step_b(1, 1, 1, 0, 0);
      chk("b_run_wrap_010000", b_time, 24'h010000);
      chk("b_no_day_at_1_oclock", b_day, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
